// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory request, DEPTH-entry FIFO of
// {instr, pc+4} feeding decode, with redirect flush and in-flight response kill.
module fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic                     ImemReq,
    output logic [ADDR_W-1:0]        ImemAddr,
    input  logic [DATA_W-1:0]        ImemRdata,
    input  logic                     ImemValid,
    input  logic                     Redirect,
    input  logic [ADDR_W-1:0]        RedirectPC,
    input  logic                     StallD,
    output logic [DATA_W-1:0]        InstrD,
    output logic [ADDR_W-1:0]        PCPlus4D,
    output logic                     ValidD,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_pending;
    logic              r_kill;

    logic [DATA_W-1:0] r_instr [DEPTH];
    logic [ADDR_W-1:0] r_pc4   [DEPTH];

    logic w_full;
    logic w_resp;
    logic w_push;
    logic w_pop;

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_resp = ImemValid && r_pending;
    assign w_pop  = (r_count != '0) && !StallD && !Redirect;
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign w_push = w_resp && !r_kill && !Redirect && (!w_full || w_pop);

    // RST gates the request so the memory sees nothing while held in reset.
    assign ImemReq  = RST && !r_pending && !w_full && !Redirect;
    assign ImemAddr = r_pc;

    assign ValidD   = (r_count != '0);
    assign InstrD   = ValidD ? r_instr[r_rd_ptr] : '0;
    assign PCPlus4D = ValidD ? r_pc4[r_rd_ptr]   : '0;
    assign Count    = r_count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc      <= RESET_PC;
            r_req_pc  <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_pending <= 1'b0;
            r_kill    <= 1'b0;
        end else if (Redirect) begin
            r_pc     <= {RedirectPC[ADDR_W-1:2], 2'b00};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            // An in-flight request either dies now or is marked to die on return.
            if (r_pending) begin
                if (ImemValid) begin
                    r_pending <= 1'b0;
                    r_kill    <= 1'b0;
                end else begin
                    r_kill    <= 1'b1;
                end
            end
        end else begin
            if (ImemReq) begin
                r_pending <= 1'b1;
                r_req_pc  <= r_pc;
                r_pc      <= r_pc + ADDR_W'(4);
            end else if (w_resp) begin
                r_pending <= 1'b0;
                r_kill    <= 1'b0;
            end
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; ValidD masks stale entries.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= ImemRdata;
            r_pc4[r_wr_ptr]   <= r_req_pc + ADDR_W'(4);
        end
    end

endmodule
